// File: rtl/master_track_fsm.sv
// Recorder mode controller: key edge detection, IDLE/RECORD/PLAYBACK/RESTART/PAUSE sequencing,
// song time counter and per-track recorded lengths.
module master_track_fsm #(
  parameter int unsigned NUM_TRACKS  = 4,
  parameter int unsigned TIMER_WIDTH = 20,
  localparam int unsigned TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   tick,
  input  logic                   key_space,
  input  logic                   key_backslash,
  input  logic                   key_r,
  input  logic                   key_p,
  input  logic [NUM_TRACKS-1:0]  key_track,
  input  logic                   loop_en,
  output logic [2:0]             current_state,
  output logic                   timer_enable,
  output logic [TIMER_WIDTH-1:0] time_count,
  output logic [TW-1:0]          active_track,
  output logic [TIMER_WIDTH-1:0] track_length,
  output logic                   len_wr,
  output logic                   play_done
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRecord   = 3'd1,
    StPlayback = 3'd2,
    StRestart  = 3'd3,
    StPause    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] time_q, time_d;
  logic [TW-1:0]          active_q, active_d;
  logic [TIMER_WIDTH-1:0] len_q [NUM_TRACKS];
  logic [TIMER_WIDTH-1:0] len_d [NUM_TRACKS];
  logic [TIMER_WIDTH-1:0] track_length_q;
  logic                   len_wr_q, len_wr_d;
  logic                   play_done_q, play_done_d;

  // Key history; cleared at reset so keys held through reset release yield one edge.
  logic                  space_q, backslash_q, r_q, p_q;
  logic [NUM_TRACKS-1:0] track_q;

  logic                  e_space, e_backslash, e_r, e_p;
  logic [NUM_TRACKS-1:0] e_track;
  logic                  trk_any;
  logic [TW-1:0]         trk_sel;
  logic                  time_max;
  logic                  track_end;

  assign e_space     = key_space & ~space_q;
  assign e_backslash = key_backslash & ~backslash_q;
  assign e_r         = key_r & ~r_q;
  assign e_p         = key_p & ~p_q;
  assign e_track     = key_track & ~track_q;

  assign time_max  = (time_q == {TIMER_WIDTH{1'b1}});
  assign track_end = (time_q >= len_q[active_q]);

  // Lowest set bit of the track edge vector wins; scan downwards so it is assigned last.
  always_comb begin
    trk_any = 1'b0;
    trk_sel = '0;
    for (int i = int'(NUM_TRACKS) - 1; i >= 0; i--) begin
      if (e_track[i]) begin
        trk_any = 1'b1;
        trk_sel = TW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    active_d    = active_q;
    len_d       = len_q;
    len_wr_d    = 1'b0;
    play_done_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (e_space) begin
          state_d = StRecord;
          time_d  = '0;
        end
      end

      StRecord: begin
        // The stop captures the count before any same-cycle tick is applied.
        if (e_backslash || (tick && time_max)) begin
          len_d[active_q] = time_q;
          len_wr_d        = 1'b1;
          time_d          = '0;
          state_d         = StPlayback;
        end else if (tick) begin
          time_d = time_q + TIMER_WIDTH'(1);
        end
      end

      StPlayback: begin
        if (e_r) begin
          state_d = StRestart;
        end else if (e_space) begin
          state_d = StRecord;
          time_d  = '0;
        end else if (e_p) begin
          state_d = StPause;
        end else if (trk_any) begin
          active_d = trk_sel;
          state_d  = StRestart;
        end else if (tick) begin
          if (track_end) begin
            play_done_d = 1'b1;
            time_d      = '0;
            if (!loop_en) begin
              state_d = StIdle;
            end
          end else begin
            time_d = time_q + TIMER_WIDTH'(1);
          end
        end
      end

      StRestart: begin
        time_d  = '0;
        state_d = StPlayback;
      end

      StPause: begin
        if (e_r) begin
          state_d = StRestart;
        end else if (e_space) begin
          state_d = StRecord;
          time_d  = '0;
        end else if (e_p) begin
          state_d = StPlayback;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      time_q         <= '0;
      active_q       <= '0;
      len_q          <= '{default: '0};
      track_length_q <= '0;
      len_wr_q       <= 1'b0;
      play_done_q    <= 1'b0;
      space_q        <= 1'b0;
      backslash_q    <= 1'b0;
      r_q            <= 1'b0;
      p_q            <= 1'b0;
      track_q        <= '0;
    end else begin
      state_q        <= state_d;
      time_q         <= time_d;
      active_q       <= active_d;
      len_q          <= len_d;
      track_length_q <= len_d[active_d];
      len_wr_q       <= len_wr_d;
      play_done_q    <= play_done_d;
      space_q        <= key_space;
      backslash_q    <= key_backslash;
      r_q            <= key_r;
      p_q            <= key_p;
      track_q        <= key_track;
    end
  end

  assign current_state = state_q;
  assign timer_enable  = (state_q == StRecord) || (state_q == StPlayback);
  assign time_count    = time_q;
  assign active_track  = active_q;
  assign track_length  = track_length_q;
  assign len_wr        = len_wr_q;
  assign play_done     = play_done_q;

endmodule

// File: tb/tb_master_track_fsm.sv
// Self-checking bench for master_track_fsm: directed scenarios plus randomized key/tick
// traffic compared every cycle against a behavioural model.
module tb_master_track_fsm;

  localparam int NT   = 4;
  localparam int TWD  = 6;
  localparam int TMAX = (1 << TWD) - 1;

  logic            clk;
  logic            resetn;
  logic            tick;
  logic            key_space, key_backslash, key_r, key_p;
  logic [NT-1:0]   key_track;
  logic            loop_en;
  logic [2:0]      current_state;
  logic            timer_enable;
  logic [TWD-1:0]  time_count;
  logic [1:0]      active_track;
  logic [TWD-1:0]  track_length;
  logic            len_wr;
  logic            play_done;

  master_track_fsm #(
    .NUM_TRACKS (NT),
    .TIMER_WIDTH(TWD)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .tick         (tick),
    .key_space    (key_space),
    .key_backslash(key_backslash),
    .key_r        (key_r),
    .key_p        (key_p),
    .key_track    (key_track),
    .loop_en      (loop_en),
    .current_state(current_state),
    .timer_enable (timer_enable),
    .time_count   (time_count),
    .active_track (active_track),
    .track_length (track_length),
    .len_wr       (len_wr),
    .play_done    (play_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model; modes use the numeric codes of the current_state output.
  int       m_mode, m_time, m_act, m_tl;
  int       m_len [NT];
  bit       m_wr, m_done;
  bit       h_space, h_bs, h_r, h_p;
  bit [3:0] h_trk;

  task automatic model_reset();
    m_mode = 0; m_time = 0; m_act = 0; m_tl = 0; m_wr = 0; m_done = 0;
    foreach (m_len[i]) m_len[i] = 0;
    h_space = 0; h_bs = 0; h_r = 0; h_p = 0; h_trk = '0;
  endtask

  task automatic model_step();
    bit       pr_space, pr_bs, pr_r, pr_p;
    bit [3:0] pr_trk;
    int       sel;
    string    ev;
    pr_space = key_space && !h_space;
    pr_bs    = key_backslash && !h_bs;
    pr_r     = key_r && !h_r;
    pr_p     = key_p && !h_p;
    pr_trk   = key_track & ~h_trk;
    h_space = key_space; h_bs = key_backslash; h_r = key_r; h_p = key_p; h_trk = key_track;
    sel = -1;
    for (int i = 0; i < NT; i++) if (pr_trk[i] && sel < 0) sel = i;
    m_wr = 0;
    m_done = 0;

    // Pick the single event that acts this cycle, by mode-specific priority.
    ev = "none";
    if (m_mode == 0) begin
      if (pr_space) ev = "rec";
    end else if (m_mode == 1) begin
      if (pr_bs || (tick && m_time == TMAX)) ev = "stop";
      else if (tick) ev = "inc";
    end else if (m_mode == 2 || m_mode == 4) begin
      if (pr_r) ev = "restart";
      else if (pr_space) ev = "rec";
      else if (pr_p) ev = (m_mode == 2) ? "pause" : "resume";
      else if (m_mode == 2 && sel >= 0) ev = "track";
      else if (m_mode == 2 && tick) ev = (m_time >= m_len[m_act]) ? "end" : "inc";
    end else if (m_mode == 3) begin
      ev = "resume0";
    end

    case (ev)
      "rec":     begin m_mode = 1; m_time = 0; end
      "stop":    begin m_len[m_act] = m_time; m_wr = 1; m_time = 0; m_mode = 2; end
      "inc":     m_time = m_time + 1;
      "restart": m_mode = 3;
      "pause":   m_mode = 4;
      "resume":  m_mode = 2;
      "track":   begin m_act = sel; m_mode = 3; end
      "end":     begin m_done = 1; m_time = 0; if (!loop_en) m_mode = 0; end
      "resume0": begin m_time = 0; m_mode = 2; end
      default:   ;
    endcase
    m_tl = m_len[m_act];
  endtask

  task automatic compare_all();
    check_eq("state", current_state, m_mode);
    check_eq("time_count", time_count, m_time);
    check_eq("active_track", active_track, m_act);
    check_eq("track_length", track_length, m_tl);
    check_eq("len_wr", len_wr, m_wr);
    check_eq("play_done", play_done, m_done);
    check_eq("timer_enable", timer_enable, (m_mode == 1 || m_mode == 2));
  endtask

  // One clock: inputs already applied; sample 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic async_reset();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic clear_keys();
    key_space = 0; key_backslash = 0; key_r = 0; key_p = 0; key_track = '0; tick = 0;
  endtask

  initial begin
    int rate, tprob;
    resetn = 1'b1;
    clear_keys();
    loop_en = 1'b0;
    model_reset();
    #3 resetn = 1'b0;
    #4;
    compare_all();
    @(negedge clk);
    resetn = 1'b1;

    // Record 10 ticks on track 0, stop with backslash.
    key_space = 1; cyc(); key_space = 0;
    check_eq("rec_state", current_state, 1);
    tick = 1; cycn(10); tick = 0;
    key_backslash = 1; cyc(); key_backslash = 0;
    check_eq("stop_len_wr", len_wr, 1);
    check_eq("stop_len", track_length, 10);
    check_eq("stop_state", current_state, 2);
    check_eq("stop_time", time_count, 0);
    cyc();
    check_eq("len_wr_pulse", len_wr, 0);

    // Re-record to 37, then asynchronous reset mid-record.
    key_space = 1; cyc(); key_space = 0;
    tick = 1; cycn(37); tick = 0;
    check_eq("rec_37", time_count, 37);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_state", current_state, 0);
    check_eq("rst_time", time_count, 0);
    check_eq("rst_len", track_length, 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;

    // len[0]=3, no loop: play_done on the 4th tick, back to IDLE.
    key_space = 1; cyc(); key_space = 0;
    tick = 1; cycn(3); tick = 0;
    key_backslash = 1; cyc(); key_backslash = 0;
    check_eq("len3", track_length, 3);
    tick = 1; cycn(3);
    check_eq("no_done_yet", play_done, 0);
    cyc(); tick = 0;
    check_eq("done_noloop", play_done, 1);
    check_eq("idle_after_end", current_state, 0);

    // Same with looping.
    loop_en = 1;
    key_space = 1; cyc(); key_space = 0;
    tick = 1; cycn(3); tick = 0;
    key_backslash = 1; cyc(); key_backslash = 0;
    tick = 1; cycn(4); tick = 0;
    check_eq("done_loop", play_done, 1);
    check_eq("loop_state", current_state, 2);
    check_eq("loop_time", time_count, 0);

    // R and space together: R wins, RESTART for one cycle.
    key_r = 1; key_space = 1; cyc(); key_r = 0; key_space = 0;
    check_eq("restart_state", current_state, 3);
    cyc();
    check_eq("restart_done", current_state, 2);

    // Record 7 on track 1, go back to track 0, then select with 0110.
    key_track = 4'b0010; cyc(); key_track = '0; cyc();
    key_space = 1; cyc(); key_space = 0;
    tick = 1; cycn(7); tick = 0;
    key_backslash = 1; cyc(); key_backslash = 0;
    key_track = 4'b0001; cyc(); key_track = '0; cyc();
    check_eq("trk0_len", track_length, 3);
    key_track = 4'b0110; cyc();
    check_eq("sel_track", active_track, 1);
    check_eq("sel_restart", current_state, 3);
    key_track = '0; cyc();
    check_eq("sel_play", current_state, 2);
    check_eq("sel_len", track_length, 7);

    // Pause freezes time; a held key gives one transition.
    tick = 1; cycn(2); tick = 0;
    key_p = 1; cyc(); key_p = 0;
    check_eq("pause_state", current_state, 4);
    tick = 1; cycn(5); tick = 0;
    check_eq("pause_frozen", time_count, 2);
    key_p = 1; cyc();
    check_eq("resume_state", current_state, 2);
    check_eq("resume_time", time_count, 2);
    cycn(20); key_p = 0;
    check_eq("held_key", current_state, 2);

    // Record saturates: tick at all-ones commits all-ones.
    key_space = 1; cyc(); key_space = 0;
    tick = 1; cycn(TMAX);
    check_eq("sat_time", time_count, TMAX);
    cyc(); tick = 0;
    check_eq("sat_wr", len_wr, 1);
    check_eq("sat_len", track_length, TMAX);
    check_eq("sat_state", current_state, 2);

    // Zero-length track ends on the first tick.
    loop_en = 0;
    key_track = 4'b0100; cyc(); key_track = '0; cyc();
    tick = 1; cyc(); tick = 0;
    check_eq("zero_len_done", play_done, 1);
    check_eq("zero_len_idle", current_state, 0);

    // Randomized traffic in blocks with varying key and tick rates.
    for (int blk = 0; blk < 20; blk++) begin
      rate  = $urandom_range(40, 3);
      tprob = $urandom_range(100, 20);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(rate - 1, 0) == 0) key_space = ~key_space;
        if ($urandom_range(rate - 1, 0) == 0) key_backslash = ~key_backslash;
        if ($urandom_range(rate - 1, 0) == 0) key_r = ~key_r;
        if ($urandom_range(rate - 1, 0) == 0) key_p = ~key_p;
        for (int k = 0; k < NT; k++)
          if ($urandom_range(2 * rate - 1, 0) == 0) key_track[k] = ~key_track[k];
        if ($urandom_range(63, 0) == 0) loop_en = ~loop_en;
        tick = ($urandom_range(99, 0) < tprob);
        if ($urandom_range(599, 0) == 0) async_reset();
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
